// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states, branch flag codes,
// default halt opcode and memory latency.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StMemWait,
        StDone
    } seq_state_t;

    localparam logic [2:0] FL_NE = 3'b000;
    localparam logic [2:0] FL_EQ = 3'b001;
    localparam logic [2:0] FL_LT = 3'b010;
    localparam logic [2:0] FL_LE = 3'b011;
    localparam logic [2:0] FL_JP = 3'b100;

    localparam logic [8:0]  HALT_OP_DEF = 9'h1FF;
    localparam int unsigned MEM_LAT_DEF = 1;

    function automatic logic is_busy(input seq_state_t s);
        return (s == StFetch) || (s == StExec) || (s == StMemWait);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch-taken evaluation from the stored flag code and Zero/Neg status bits.
module branch_cond
    import seq_pkg::*;
(
    input  logic [2:0] flag_i,
    input  logic       zero_i,
    input  logic       neg_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (flag_i)
            FL_NE:   taken_o = ~zero_i;
            FL_EQ:   taken_o = zero_i;
            FL_LT:   taken_o = neg_i;
            FL_LE:   taken_o = neg_i | zero_i;
            FL_JP:   taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: PC, branch flag, Z/N status and one-shot write enables.
// Optional cycle counter port CycleCount is built when SEQ_CYCLE_COUNT_EN is defined.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned PC_W    = 12,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF,
    parameter logic [8:0]  HALT_OP = HALT_OP_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic [8:0]      Instr,
    input  logic            Branch,
    input  logic            FlagWrite,
    input  logic [2:0]      Flag,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    input  logic            MemWrite,
    input  logic [PC_W-1:0] Target,
    input  logic            AluZero,
    input  logic            AluNeg,
    output logic [PC_W-1:0] PC,
    output logic            RegWriteEn,
    output logic            MemWriteEn,
    output logic            Busy,
`ifdef SEQ_CYCLE_COUNT_EN
    output logic [15:0]     CycleCount,
`endif
    output logic            Done
);

    localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((MEM_LAT == 0) ? 32'd0 : MEM_LAT - 1);

    seq_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic [2:0]      flag_q, flag_d;
    logic            z_q, z_d, n_q, n_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            taken;
    logic            start_acc;

    branch_cond u_branch_cond (
        .flag_i  (flag_q),
        .zero_i  (z_q),
        .neg_i   (n_q),
        .taken_o (taken)
    );

    assign pc_inc    = pc_q + PC_W'(1);
    assign start_acc = Start && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flag_d     = flag_q;
        z_d        = z_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        RegWriteEn = 1'b0;
        MemWriteEn = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start_acc) begin
                    pc_d    = StartAddr;
                    flag_d  = 3'b000;
                    z_d     = 1'b0;
                    n_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StExec;
            StExec: begin
                if (Instr == HALT_OP) begin
                    state_d = StDone;
                end else begin
                    RegWriteEn = RegWrite & ~MemtoReg;
                    MemWriteEn = MemWrite;
                    state_d    = StFetch;
                    pc_d       = pc_inc;
                    if (RegWrite && !MemtoReg) begin
                        z_d = AluZero;
                        n_d = AluNeg;
                    end
                    if (Branch && FlagWrite) begin
                        flag_d = Flag;
                    end else if (Branch && taken) begin
                        pc_d = Target;
                    end
                    if (MemtoReg) begin
                        if (MEM_LAT == 0) begin
                            RegWriteEn = 1'b1;
                        end else begin
                            // PC stays on the lb until its delayed write-back retires
                            pc_d    = pc_q;
                            cnt_d   = '0;
                            state_d = StMemWait;
                        end
                    end
                end
            end
            StMemWait: begin
                if (cnt_q == CntLast) begin
                    RegWriteEn = 1'b1;
                    pc_d       = pc_inc;
                    state_d    = StFetch;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            flag_q  <= 3'b000;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flag_q  <= flag_d;
            z_q     <= z_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC   = pc_q;
    assign Busy = is_busy(state_q);
    assign Done = (state_q == StDone);

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (start_acc) begin
            cyc_d = '0;
        end else if (Busy && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign CycleCount = cyc_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: bench-side ROM/decoder, write-enable scoreboard.
module tb_instr_sequencer;

    localparam int unsigned PC_W    = 12;
    localparam int unsigned MEM_LAT = 3;
    localparam logic [8:0]  HALT    = 9'h1FF;

    typedef enum logic [2:0] {KNop, KAlu, KSbf, KB, KLb, KSw, KHalt} kind_t;
    typedef struct packed {
        kind_t           kind;
        logic [2:0]      flag;
        logic [PC_W-1:0] target;
        logic            z;
        logic            n;
    } rom_ent_t;

    rom_ent_t rom [4096];
    rom_ent_t rom_e;

    logic            Clk = 1'b0;
    logic            Reset, Start;
    logic [PC_W-1:0] StartAddr, Target, PC;
    logic [8:0]      Instr;
    logic            Branch, FlagWrite, MemtoReg, RegWrite, MemWrite, AluZero, AluNeg;
    logic [2:0]      Flag;
    logic            RegWriteEn, MemWriteEn, Busy, Done;
`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0]     CycleCount;
`endif

    logic [PC_W:0]   exp_q [$];
    logic [PC_W:0]   ev;
    int              n_checks = 0;
    int              n_fail   = 0;

    instr_sequencer #(
        .PC_W    (PC_W),
        .MEM_LAT (MEM_LAT),
        .HALT_OP (HALT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Instr      (Instr),
        .Branch     (Branch),
        .FlagWrite  (FlagWrite),
        .Flag       (Flag),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Target     (Target),
        .AluZero    (AluZero),
        .AluNeg     (AluNeg),
        .PC         (PC),
        .RegWriteEn (RegWriteEn),
        .MemWriteEn (MemWriteEn),
        .Busy       (Busy),
`ifdef SEQ_CYCLE_COUNT_EN
        .CycleCount (CycleCount),
`endif
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    // Bench ROM + decoder; HALT deliberately raises RegWrite/MemWrite to exercise gating.
    always_comb begin
        rom_e     = rom[PC];
        Instr     = (rom_e.kind == KHalt) ? HALT : 9'h000;
        Branch    = (rom_e.kind == KSbf) || (rom_e.kind == KB);
        FlagWrite = (rom_e.kind == KSbf);
        Flag      = rom_e.flag;
        MemtoReg  = (rom_e.kind == KLb);
        RegWrite  = (rom_e.kind == KAlu) || (rom_e.kind == KLb) || (rom_e.kind == KHalt);
        MemWrite  = (rom_e.kind == KSw) || (rom_e.kind == KHalt);
        Target    = rom_e.target;
        AluZero   = rom_e.z;
        AluNeg    = rom_e.n;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [PC_W-1:0] a, input kind_t k, input logic [2:0] f,
                       input logic [PC_W-1:0] t, input logic z, input logic n);
        rom[a] = '{kind: k, flag: f, target: t, z: z, n: n};
    endtask

    task automatic exp_reg(input logic [PC_W-1:0] a);
        exp_q.push_back({1'b0, a});
    endtask

    task automatic exp_mem(input logic [PC_W-1:0] a);
        exp_q.push_back({1'b1, a});
    endtask

    // Scoreboard: each enable pulse must match the next expected {is_mem, pc}.
    always @(negedge Clk) begin
        if (!Reset && (RegWriteEn || MemWriteEn)) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_we", {30'b0, RegWriteEn, MemWriteEn}, 32'd0);
            end else begin
                ev = exp_q.pop_front();
                check_eq("we_event", {19'b0, MemWriteEn, PC}, {19'b0, ev});
            end
        end
    end

    task automatic run_prog(input string tag, input logic [PC_W-1:0] addr, input int exp_cyc,
                            input logic [PC_W-1:0] exp_pc, input int poke_at);
        int cyc = 0;
        @(negedge Clk);
        StartAddr = addr;
        Start     = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        check_eq({tag, "_busy0"}, {31'b0, Busy}, 32'd1);
        check_eq({tag, "_done0"}, {31'b0, Done}, 32'd0);
        check_eq({tag, "_pc0"}, {20'b0, PC}, {20'b0, addr});
`ifdef SEQ_CYCLE_COUNT_EN
        check_eq({tag, "_cc0"}, {16'b0, CycleCount}, 32'd0);
`endif
        while (!Done && cyc < 200) begin
            if (cyc == poke_at) begin
                @(negedge Clk);
                StartAddr = 12'h030;
                Start     = 1'b1;
                @(posedge Clk);
                #1 Start = 1'b0;
            end else begin
                @(posedge Clk);
                #1;
            end
            cyc++;
        end
        check_eq({tag, "_cycles"}, cyc, exp_cyc);
        check_eq({tag, "_pc"}, {20'b0, PC}, {20'b0, exp_pc});
        check_eq({tag, "_busy"}, {31'b0, Busy}, 32'd0);
        check_eq({tag, "_drain"}, exp_q.size(), 32'd0);
        repeat (3) @(posedge Clk);
        #1;
        check_eq({tag, "_done_hold"}, {31'b0, Done}, 32'd1);
        check_eq({tag, "_pc_hold"}, {20'b0, PC}, {20'b0, exp_pc});
`ifdef SEQ_CYCLE_COUNT_EN
        check_eq({tag, "_cc_frozen"}, {16'b0, CycleCount}, exp_cyc);
`endif
    endtask

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        StartAddr = '0;
        for (int i = 0; i < 4096; i++) begin
            rom[i] = '{kind: KNop, flag: 3'b000, target: '0, z: 1'b0, n: 1'b0};
        end
        repeat (2) @(posedge Clk);
        #1;
        check_eq("rst_pc", {20'b0, PC}, 32'd0);
        check_eq("rst_busy", {31'b0, Busy}, 32'd0);
        check_eq("rst_done", {31'b0, Done}, 32'd0);
        check_eq("rst_en", {30'b0, RegWriteEn, MemWriteEn}, 32'd0);
`ifdef SEQ_CYCLE_COUNT_EN
        check_eq("rst_cc", {16'b0, CycleCount}, 32'd0);
`endif
        @(negedge Clk);
        Reset = 1'b0;

        // Three ALU ops then HALT
        put(12'h010, KAlu, 3'd0, 12'h000, 1'b0, 1'b0);
        put(12'h011, KAlu, 3'd0, 12'h000, 1'b0, 1'b1);
        put(12'h012, KAlu, 3'd0, 12'h000, 1'b1, 1'b0);
        put(12'h013, KHalt, 3'd0, 12'h000, 1'b0, 1'b0);
        exp_reg(12'h010); exp_reg(12'h011); exp_reg(12'h012);
        run_prog("alu3", 12'h010, 8, 12'h013, -1);

        // beq taken (Z=1)
        put(12'h020, KAlu, 3'd0, 12'h000, 1'b1, 1'b0);
        put(12'h021, KSbf, 3'b001, 12'h000, 1'b0, 1'b0);
        put(12'h022, KB, 3'd0, 12'h040, 1'b0, 1'b0);
        put(12'h040, KHalt, 3'd0, 12'h000, 1'b0, 1'b0);
        exp_reg(12'h020);
        run_prog("beq_tk", 12'h020, 8, 12'h040, -1);

        // beq not taken (Z=0)
        put(12'h030, KAlu, 3'd0, 12'h000, 1'b0, 1'b0);
        put(12'h031, KSbf, 3'b001, 12'h000, 1'b0, 1'b0);
        put(12'h032, KB, 3'd0, 12'h040, 1'b0, 1'b0);
        put(12'h033, KHalt, 3'd0, 12'h000, 1'b0, 1'b0);
        exp_reg(12'h030);
        run_prog("beq_nt", 12'h030, 8, 12'h033, -1);

        // jp always taken
        put(12'h050, KAlu, 3'd0, 12'h000, 1'b0, 1'b0);
        put(12'h051, KSbf, 3'b100, 12'h000, 1'b0, 1'b0);
        put(12'h052, KB, 3'd0, 12'h005, 1'b0, 1'b0);
        put(12'h005, KHalt, 3'd0, 12'h000, 1'b0, 1'b0);
        exp_reg(12'h050);
        run_prog("jp", 12'h050, 8, 12'h005, -1);

        // flag 101 never taken
        put(12'h060, KAlu, 3'd0, 12'h000, 1'b1, 1'b1);
        put(12'h061, KSbf, 3'b101, 12'h000, 1'b0, 1'b0);
        put(12'h062, KB, 3'd0, 12'h005, 1'b0, 1'b0);
        put(12'h063, KHalt, 3'd0, 12'h000, 1'b0, 1'b0);
        exp_reg(12'h060);
        run_prog("fl101", 12'h060, 8, 12'h063, -1);

        // lt taken on N=1
        put(12'h070, KAlu, 3'd0, 12'h000, 1'b0, 1'b1);
        put(12'h071, KSbf, 3'b010, 12'h000, 1'b0, 1'b0);
        put(12'h072, KB, 3'd0, 12'h080, 1'b0, 1'b0);
        put(12'h080, KHalt, 3'd0, 12'h000, 1'b0, 1'b0);
        exp_reg(12'h070);
        run_prog("blt", 12'h070, 8, 12'h080, -1);

        // Start clears flag back to ne: Z=1 so b falls through (lt would have taken it)
        put(12'h0C0, KAlu, 3'd0, 12'h000, 1'b1, 1'b1);
        put(12'h0C1, KB, 3'd0, 12'h0D0, 1'b0, 1'b0);
        put(12'h0C2, KHalt, 3'd0, 12'h000, 1'b0, 1'b0);
        put(12'h0D0, KHalt, 3'd0, 12'h000, 1'b0, 1'b0);
        exp_reg(12'h0C0);
        run_prog("flag_clr", 12'h0C0, 6, 12'h0C2, -1);

        // lb stall, store, and Z preserved across lb
        put(12'h090, KAlu, 3'd0, 12'h000, 1'b1, 1'b0);
        put(12'h091, KLb, 3'd0, 12'h000, 1'b0, 1'b1);
        put(12'h092, KSw, 3'd0, 12'h000, 1'b0, 1'b0);
        put(12'h093, KSbf, 3'b001, 12'h000, 1'b0, 1'b0);
        put(12'h094, KB, 3'd0, 12'h0A0, 1'b0, 1'b0);
        put(12'h0A0, KHalt, 3'd0, 12'h000, 1'b0, 1'b0);
        exp_reg(12'h090); exp_reg(12'h091); exp_mem(12'h092);
        run_prog("lb", 12'h090, 15, 12'h0A0, -1);

        // PC wrap
        put(12'hFFF, KAlu, 3'd0, 12'h000, 1'b0, 1'b0);
        put(12'h000, KHalt, 3'd0, 12'h000, 1'b0, 1'b0);
        exp_reg(12'hFFF);
        run_prog("wrap", 12'hFFF, 4, 12'h000, -1);

        // Start pulsed while busy is ignored
        exp_reg(12'h010); exp_reg(12'h011); exp_reg(12'h012);
        run_prog("busy_start", 12'h010, 8, 12'h013, 3);

        // Reset during MEMWAIT
        put(12'h0B0, KLb, 3'd0, 12'h000, 1'b0, 1'b0);
        @(negedge Clk);
        StartAddr = 12'h0B0;
        Start     = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("mw_busy", {31'b0, Busy}, 32'd1);
        check_eq("mw_no_we", {31'b0, RegWriteEn}, 32'd0);
        Reset = 1'b1;
        #1;
        check_eq("mw_rst_pc", {20'b0, PC}, 32'd0);
        check_eq("mw_rst_en", {30'b0, RegWriteEn, MemWriteEn}, 32'd0);
        check_eq("mw_rst_busy", {30'b0, Busy, Done}, 32'd0);
        @(posedge Clk);
        #1;
        check_eq("mw_rst_idle", {30'b0, Busy, Done}, 32'd0);
`ifdef SEQ_CYCLE_COUNT_EN
        check_eq("mw_rst_cc", {16'b0, CycleCount}, 32'd0);
`endif
        @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_eq("final_drain", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
